prince_dec_iter: RTL and testbench

Iterative, round-per-cycle PRINCE decryption engine. It recovers a 64-bit plaintext from a 64-bit ciphertext under a 128-bit key. It is the sequential receive-side counterpart to the combinational PRINCE datapath and is used where area matters more than latency. Input and output each use a valid/ready handshake, so the block sits between a ciphertext source and a plaintext sink.

---
 rtl/prince_pkg.sv | 80 ++++++++
 rtl/prince_dec_step.sv | 28 ++
 rtl/prince_dec_iter.sv | 90 +++++++++
 tb/tb_prince_dec_iter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_pkg.sv
// Shared PRINCE constants, S-box and linear-layer helpers, and the FSM state type
// used by the iterative decryption engine.
package prince_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;

    localparam logic [63:0] RC [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };

    localparam logic [3:0] SBOX [16] = '{
        4'hb, 4'hf, 4'h3, 4'h2, 4'ha, 4'hc, 4'h9, 4'h1,
        4'h6, 4'h7, 4'h8, 4'h0, 4'he, 4'h5, 4'hd, 4'h4
    };
    localparam logic [3:0] SBOX_INV [16] = '{
        4'hb, 4'h7, 4'h3, 4'h2, 4'hf, 4'hd, 4'h8, 4'h9,
        4'ha, 4'h6, 4'h4, 4'h0, 4'h5, 4'he, 4'hc, 4'h1
    };

    // Column i is the output pattern driven by input bit i of the M-hat(0) block;
    // M-hat(1) is the same table rotated by one nibble column.
    localparam logic [15:0] MHAT0 [16] = '{
        16'h0111, 16'h2220, 16'h4404, 16'h8088,
        16'h1011, 16'h0222, 16'h4440, 16'h8808,
        16'h1101, 16'h2022, 16'h0444, 16'h8880,
        16'h1110, 16'h2202, 16'h4044, 16'h0888
    };

    // Nibble j (counted from the most significant end) takes input nibble SR_PERM[j].
    localparam int SR_PERM [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        for (int i = 0; i < 16; i++)
            y[4*i +: 4] = inv ? SBOX_INV[x[4*i +: 4]] : SBOX[x[4*i +: 4]];
        return y;
    endfunction

    function automatic logic [15:0] mhat(input logic [15:0] x, input logic one);
        logic [15:0] y;
        logic [3:0]  idx;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i) + (one ? 4'd12 : 4'd0);
            if (x[i])
                y = y ^ MHAT0[idx];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {mhat(x[63:48], 1'b0), mhat(x[47:32], 1'b1),
                mhat(x[31:16], 1'b1), mhat(x[15:0], 1'b0)};
    endfunction

    function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        for (int j = 0; j < 16; j++) begin
            if (inv)
                y[63-4*SR_PERM[j] -: 4] = x[63-4*j -: 4];
            else
                y[63-4*j -: 4] = x[63-4*SR_PERM[j] -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_layer(input logic [63:0] x);
        return shift_rows(m_prime(x), 1'b0);
    endfunction

    function automatic logic [63:0] m_inv_layer(input logic [63:0] x);
        return m_prime(shift_rows(x, 1'b1));
    endfunction

endpackage

// File: rtl/prince_dec_step.sv
// Combinational PRINCE decryption round selected by the step counter (1..11).
// Step 11 omits the final k0 whitening, which the top applies on output.
module prince_dec_step
    import prince_pkg::*;
(
    input  logic [63:0] state,
    input  logic [3:0]  cnt,
    input  logic [63:0] kc,
    output logic [63:0] next_state
);

    logic [3:0] rc_idx;
    assign rc_idx = cnt - 4'd1;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        if (cnt >= 4'd1 && cnt <= 4'd5)
            next_state = m_layer(s_layer(state, 1'b0)) ^ RC[cnt] ^ kc;
        else if (cnt == 4'd6)
            next_state = s_layer(m_prime(s_layer(state, 1'b0)), 1'b1);
        else if (cnt >= 4'd7 && cnt <= 4'd10)
            next_state = s_layer(m_inv_layer(state ^ RC[rc_idx] ^ kc), 1'b1);
        else if (cnt == 4'd11)
            next_state = s_layer(m_inv_layer(state ^ RC[rc_idx] ^ kc), 1'b1) ^ RC[11] ^ kc;
    end

endmodule

// File: rtl/prince_dec_iter.sv
// Iterative round-per-cycle PRINCE decryption with valid/ready on both sides.
// Define PRINCE_DEC_ZEROIZE_EN to wipe state, keys and out_data on the output handshake.
module prince_dec_iter
    import prince_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);

    fsm_t        fsm;
    logic [3:0]  cnt;
    logic [63:0] state;
    logic [63:0] k0;
    logic [63:0] kc;
    logic [63:0] step_out;
    logic [63:0] k0_prime;

    assign k0_prime = {in_key[64], in_key[127:65]} ^ {63'd0, in_key[127]};

    prince_dec_step u_step (
        .state      (state),
        .cnt        (cnt),
        .kc         (kc),
        .next_state (step_out)
    );

    // NOTE: all state updates use non-blocking assignments; the datapath and key
    // registers are reset too, so an aborted block leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            state     <= '0;
            k0        <= '0;
            kc        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        k0       <= in_key[127:64];
                        kc       <= in_key[63:0] ^ ALPHA;
                        state    <= in_data ^ k0_prime ^ in_key[63:0] ^ ALPHA ^ RC[0];
                        cnt      <= 4'd1;
                        in_ready <= 1'b0;
                        fsm      <= RUN;
                    end
                end
                RUN: begin
                    state <= step_out;
                    if (cnt == 4'd11) begin
                        out_data  <= step_out ^ k0;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
`ifdef PRINCE_DEC_ZEROIZE_EN
                        state    <= '0;
                        k0       <= '0;
                        kc       <= '0;
                        out_data <= '0;
`else
                        // Datapath registers keep their last values after delivery.
                        state    <= state;
`endif
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prince_dec_iter.sv
// Self-checking bench: a PRINCE encryption model built from the cipher definition
// produces ciphertexts whose plaintexts the decryptor must recover.
module tb_prince_dec_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    int n_cmp = 0;
    int n_bad = 0;

    prince_dec_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: PRINCE encryption from its definition ----------
    localparam logic [3:0] SB [16] = '{4'hb, 4'hf, 4'h3, 4'h2, 4'ha, 4'hc, 4'h9, 4'h1,
                                       4'h6, 4'h7, 4'h8, 4'h0, 4'he, 4'h5, 4'hd, 4'h4};
    localparam logic [63:0] RCM [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};

    function automatic logic [63:0] sub(input logic [63:0] x, input bit inv);
        logic [3:0]  tab [16];
        logic [63:0] y;
        for (int i = 0; i < 16; i++) begin
            if (inv) tab[SB[i]] = 4'(i);
            else     tab[i] = SB[i];
        end
        for (int n = 0; n < 16; n++) y[4*n +: 4] = tab[x[4*n +: 4]];
        return y;
    endfunction

    // Block (r,c) of M-hat(h) is a 4x4 identity with one bit removed.
    function automatic logic [15:0] mhat_m(input logic [15:0] x, input int h);
        logic [15:0] y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    if (b != (r + c + 1 - h) % 4) y[4*r+b] = y[4*r+b] ^ x[4*c+b];
        return y;
    endfunction

    function automatic logic [63:0] mp_m(input logic [63:0] x);
        return {mhat_m(x[63:48], 0), mhat_m(x[47:32], 1), mhat_m(x[31:16], 1), mhat_m(x[15:0], 0)};
    endfunction

    // Nibble n (from the MSB) lies in row n%4; row r rotates left by r columns.
    function automatic logic [63:0] sr_m(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        int src;
        for (int n = 0; n < 16; n++) begin
            src = (n + 4 * (n % 4)) % 16;
            if (inv) y[63-4*src -: 4] = x[63-4*n -: 4];
            else     y[63-4*n -: 4] = x[63-4*src -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [127:0] key);
        logic [63:0] k0, k1, k0p, s;
        k0  = key[127:64];
        k1  = key[63:0];
        k0p = {k0[0], k0[63:1]} ^ (k0 >> 63);
        s   = pt ^ k0 ^ k1 ^ RCM[0];
        for (int i = 1; i <= 5; i++) s = sr_m(mp_m(sub(s, 0)), 0) ^ RCM[i] ^ k1;
        s = sub(mp_m(sub(s, 0)), 1);
        for (int i = 6; i <= 10; i++) s = sub(mp_m(sr_m(s ^ RCM[i] ^ k1, 1)), 1);
        return s ^ RCM[11] ^ k1 ^ k0p;
    endfunction

    // ---------------- monitor and compare process ----------------
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          pending = 0;
    bit          seen = 0;
    bit          hs = 0;
    logic [63:0] exp_next = '0;
    logic [63:0] exp_cur = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pending = 0;
            hs = 0;
        end else begin
            if (in_valid && in_ready) begin
                pending = 1;
                seen    = 0;
                acc_cyc = cyc;
                exp_cur = exp_next;
            end
            if (out_valid && out_ready) begin
                pending = 0;
                hs      = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (hs) begin
                hs = 0;
                check("post_hs_out_valid", 64'(out_valid), 64'd0);
                check("post_hs_in_ready", 64'(in_ready), 64'd1);
`ifdef PRINCE_DEC_ZEROIZE_EN
                check("post_hs_out_data", out_data, 64'd0);
`else
                check("post_hs_out_data", out_data, exp_cur);
`endif
            end else if (pending) begin
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1;
                        check("latency", 64'(cyc - acc_cyc), 64'd11);
                    end
                    check("out_data", out_data, exp_cur);
                    check("in_ready_done", 64'(in_ready), 64'd0);
                end else begin
                    check("in_ready_run", 64'(in_ready), 64'd0);
                end
            end else if (out_valid) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [63:0] ct, input logic [127:0] key, input logic [63:0] pt,
                        input int hold, input bit poke);
        int t = 0;
        while (!in_ready && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_in_ready", 64'(in_ready), 64'd1);
        exp_next = pt;
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        if (poke) begin
            for (int i = 0; i < 8; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_out_valid", 64'(out_valid), 64'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [63:0]  kat_ct  [5] = '{64'h818665aa0d02dfda, 64'h604ae6ca03c20ada, 64'h9fb51935fc3df524,
                                  64'h78a54cbe737bb7ef, 64'hae25ad3ca8fa9ccf};
    logic [127:0] kat_key [5] = '{128'h0, 128'h0, {64'hffffffffffffffff, 64'h0},
                                  {64'h0, 64'hffffffffffffffff}, {64'h0, 64'hfedcba9876543210}};
    logic [63:0]  kat_pt  [5] = '{64'h0, 64'hffffffffffffffff, 64'h0, 64'h0, 64'h0123456789abcdef};

    initial begin
        logic [63:0]  pt;
        logic [127:0] key;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);

        for (int i = 0; i < 5; i++)
            check($sformatf("model_kat%0d", i), enc(kat_pt[i], kat_key[i]), kat_ct[i]);

        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 5; i++)
            send(kat_ct[i], kat_key[i], kat_pt[i], (i == 4) ? 20 : 0, i == 4);

        // Abort a decryption with reset while step 5 is pending.
        exp_next = kat_pt[4];
        in_valid = 1'b1;
        in_data  = kat_ct[4];
        in_key   = kat_key[4];
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_out_data", out_data, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_release_in_ready", 64'(in_ready), 64'd1);
        check("abort_release_out_valid", 64'(out_valid), 64'd0);
        send(kat_ct[4], kat_key[4], kat_pt[4], 0, 0);

        for (int i = 0; i < 30; i++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            send(enc(pt, key), key, pt, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
